// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
//   Shared types and constants for the UART receive path.
//   - uart_rx_state_t : receiver FSM state encoding
//   - uart_div()      : baud prescaler divisor, rounded to nearest
//   - uart_maj3()     : 2-of-3 majority vote used for bit decisions
//   - UART_OVS        : oversampling factor (sub-bit ticks per bit)
//   - UART_S0/S1/S2   : sub-bit sample points, decision taken at UART_S2
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int UART_OVS = 16;
    localparam int UART_S0  = 7;
    localparam int UART_S1  = 8;
    localparam int UART_S2  = 9;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4,
        RX_BRK    = 3'd5
    } uart_rx_state_t;

    // Rounded integer division: (clk + 8*baud) / (16*baud).
    function automatic int uart_div(input int clk_hz, input int baud);
        return (clk_hz + 8 * baud) / (16 * baud);
    endfunction

    function automatic logic uart_maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_fifo_sa.sv
// ---------------------------------------------------------------------------
// uart_fifo_sa
//   Show-ahead synchronous FIFO, distributed-RAM array plus pointers.
//   The head entry is always presented on o_dout from a register, so o_dout
//   reflects a push into an empty FIFO, or a pop, on the cycle after the edge.
//
// Ports
//   i_clk    : clock
//   i_rst_n  : synchronous active-low reset (pointers and o_dout only)
//   i_push   : write request; accepted when not full, or when full with an
//              effective pop in the same cycle
//   i_din    : write data
//   o_full   : FIFO holds 2**AW entries
//   i_pop    : read request; ignored while empty
//   o_dout   : registered head entry, meaningful while !o_empty
//   o_empty  : FIFO holds no entries
// ---------------------------------------------------------------------------
module uart_fifo_sa #(
    parameter int W  = 8,
    parameter int AW = 4
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_push,
    input  logic [W-1:0] i_din,
    output logic         o_full,
    input  logic         i_pop,
    output logic [W-1:0] o_dout,
    output logic         o_empty
);

    localparam int DEPTH = 1 << AW;

    logic [W-1:0] r_mem [0:DEPTH-1];
    logic [AW:0]  r_wr;
    logic [AW:0]  r_rd;
    logic [W-1:0] r_dout;

    logic         w_full;
    logic         w_empty;
    logic         w_do_pop;
    logic         w_do_push;
    logic [AW:0]  w_rd_next;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign w_full    = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
    assign w_empty   = (r_wr == r_rd);
    assign w_do_pop  = i_pop & ~w_empty;
    assign w_do_push = i_push & (~w_full | w_do_pop);
    assign w_rd_next = r_rd + {{AW{1'b0}}, w_do_pop};

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr[AW-1:0]] <= i_din;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr   <= '0;
            r_rd   <= '0;
            r_dout <= '0;
        end else begin
            if (w_do_push) begin
                r_wr <= r_wr + 1'b1;
            end
            r_rd <= w_rd_next;
            // The next head is being written this very cycle when the FIFO
            // is (or becomes) down to the entry under the write pointer:
            // forward the incoming data instead of the stale array word.
            if (w_do_push && (r_wr[AW-1:0] == w_rd_next[AW-1:0])) begin
                r_dout <= i_din;
            end else begin
                r_dout <= r_mem[w_rd_next[AW-1:0]];
            end
        end
    end

    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_dout  = r_dout;

endmodule

// File: rtl/uart_rx_fifo8.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo8
//   UART receiver, 8 data bits LSB first, 1 stop bit, 16x oversampling with
//   2-of-3 majority voting around mid-bit, feeding a show-ahead FIFO.
//   Optional even parity bit when the macro UART_RX_PARITY_EN is defined;
//   without it the receiver is strictly 8N1.
//
// Handshake: the FIFO head is offered on dout while valid=1; the consumer
//   takes it by holding read=1 for one clock while valid=1. read with
//   valid=0 is ignored. There is no back-pressure on the line: a byte that
//   arrives while the FIFO is full and not being popped is dropped.
//
// Ports
//   m_clock     : sole clock
//   p_reset_n   : synchronous active-low reset
//   UART_RX     : raw asynchronous serial input, idle high
//   dout        : FIFO head byte
//   valid       : FIFO not empty
//   read        : pop request
//   framing_err : sticky, bad stop bit (or bad parity)
//   overrun     : sticky, byte dropped on full FIFO
//   err_clr     : clears both sticky flags; a same-cycle set wins
//   busy        : registered, receiver FSM not idle
//   dbg_state   : current receiver FSM state (uart_rx_state_t encoding)
// ---------------------------------------------------------------------------
module uart_rx_fifo8
    import uart_pkg::*;
#(
    parameter int CLK_HZ  = 50000000,
    parameter int BAUD    = 115200,
    parameter int FIFO_AW = 4
) (
    input  logic       m_clock,
    input  logic       p_reset_n,
    input  logic       UART_RX,
    output logic [7:0] dout,
    output logic       valid,
    input  logic       read,
    output logic       framing_err,
    output logic       overrun,
    input  logic       err_clr,
    output logic       busy,
    output logic [2:0] dbg_state
);

    localparam int DIV = uart_div(CLK_HZ, BAUD);
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

    // ---------------- synchronizer and edge detect ----------------
    logic r_sync1;
    logic r_sync2;
    logic r_rxs_d;
    logic w_rxs;
    logic w_fall;

    assign w_rxs  = r_sync2;
    assign w_fall = r_rxs_d & ~w_rxs;

    always_ff @(posedge m_clock) begin
        if (!p_reset_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_rxs_d <= 1'b1;
        end else begin
            r_sync1 <= UART_RX;
            r_sync2 <= r_sync1;
            r_rxs_d <= r_sync2;
        end
    end

    // ---------------- state, prescaler, sub-bit counter ----------------
    uart_rx_state_t r_state;
    uart_rx_state_t w_next;

    logic [PW-1:0] r_pre;
    logic [3:0]    r_sc;
    logic [2:0]    r_bitidx;
    logic [7:0]    r_sr;
    logic          r_s0;
    logic          r_s1;
    logic          r_busy;
    logic          r_fe;
    logic          r_ov;

    logic          w_start;
    logic          w_tick;
    logic          w_dec;
    logic          w_bit;
    logic          w_bit_end;
    logic          w_push;
    logic          w_set_fe;
    logic          w_set_ov;
    logic          w_full;
    logic          w_empty;

    assign w_start   = (r_state == RX_IDLE) && w_fall;
    assign w_tick    = (r_pre == PW'(DIV - 1));
    assign w_dec     = w_tick && (r_sc == 4'(UART_S2));
    assign w_bit     = uart_maj3(r_s0, r_s1, w_rxs);
    assign w_bit_end = w_tick && (r_sc == 4'(UART_OVS - 1));

    // Process 1: state register.
    always_ff @(posedge m_clock) begin
        if (!p_reset_n) begin
            r_state <= RX_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Process 2: next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            RX_IDLE: begin
                if (w_fall) begin
                    w_next = RX_START;
                end
            end
            RX_START: begin
                // A start bit that votes high at mid-bit was a glitch.
                if (w_dec && w_bit) begin
                    w_next = RX_IDLE;
                end else if (w_bit_end) begin
                    w_next = RX_DATA;
                end
            end
            RX_DATA: begin
                if (w_bit_end && (r_bitidx == 3'd7)) begin
`ifdef UART_RX_PARITY_EN
                    w_next = RX_PARITY;
`else
                    w_next = RX_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            RX_PARITY: begin
                if (w_bit_end) begin
                    w_next = RX_STOP;
                end
            end
`endif
            RX_STOP: begin
                // Leave at mid-stop so the next start edge is caught even
                // when the transmitter runs slightly fast.
                if (w_dec) begin
                    w_next = w_bit ? RX_IDLE : RX_BRK;
                end
            end
            RX_BRK: begin
                if (w_rxs) begin
                    w_next = RX_IDLE;
                end
            end
            default: w_next = RX_IDLE;
        endcase
    end

    // ---------------- optional parity check ----------------
`ifdef UART_RX_PARITY_EN
    logic r_par_err;
    logic w_par_bad;

    // Even parity: data bits XOR parity bit must be zero.
    assign w_par_bad = (r_state == RX_PARITY) && w_dec && ((^r_sr) ^ w_bit);

    always_ff @(posedge m_clock) begin
        if (!p_reset_n) begin
            r_par_err <= 1'b0;
        end else if (r_state == RX_START) begin
            r_par_err <= 1'b0;
        end else if (w_par_bad) begin
            r_par_err <= 1'b1;
        end
    end
`endif

    // Process 3: outputs of the FSM (push request and error events).
    always_comb begin
        w_push   = 1'b0;
        w_set_fe = 1'b0;
        if ((r_state == RX_STOP) && w_dec) begin
            if (w_bit) begin
`ifdef UART_RX_PARITY_EN
                w_push = ~r_par_err;
`else
                w_push = 1'b1;
`endif
            end else begin
                w_set_fe = 1'b1;
            end
        end
`ifdef UART_RX_PARITY_EN
        if (w_par_bad) begin
            w_set_fe = 1'b1;
        end
`endif
    end

    // A full FIFO always has a head, so read alone means an effective pop.
    assign w_set_ov = w_push & w_full & ~read;

    // ---------------- timing and datapath registers ----------------
    always_ff @(posedge m_clock) begin
        if (!p_reset_n) begin
            r_pre    <= '0;
            r_sc     <= '0;
            r_bitidx <= '0;
            r_sr     <= '0;
            r_s0     <= 1'b1;
            r_s1     <= 1'b1;
            r_busy   <= 1'b0;
        end else begin
            // Re-phase the prescaler on the start edge so ticks line up
            // with the incoming bit cells.
            if (w_start || w_tick) begin
                r_pre <= '0;
            end else begin
                r_pre <= r_pre + 1'b1;
            end

            if (r_state == RX_IDLE) begin
                r_sc <= '0;
            end else if (w_tick) begin
                r_sc <= r_sc + 1'b1;
            end

            if (w_tick && (r_sc == 4'(UART_S0))) begin
                r_s0 <= w_rxs;
            end
            if (w_tick && (r_sc == 4'(UART_S1))) begin
                r_s1 <= w_rxs;
            end

            if (r_state == RX_START) begin
                r_bitidx <= '0;
            end else if ((r_state == RX_DATA) && w_bit_end) begin
                r_bitidx <= r_bitidx + 1'b1;
            end

            // LSB arrives first: shift right, new bit enters at the top.
            if ((r_state == RX_DATA) && w_dec) begin
                r_sr <= {w_bit, r_sr[7:1]};
            end

            r_busy <= (w_next != RX_IDLE);
        end
    end

    // ---------------- sticky flags ----------------
    always_ff @(posedge m_clock) begin
        if (!p_reset_n) begin
            r_fe <= 1'b0;
            r_ov <= 1'b0;
        end else begin
            if (w_set_fe) begin
                r_fe <= 1'b1;
            end else if (err_clr) begin
                r_fe <= 1'b0;
            end
            if (w_set_ov) begin
                r_ov <= 1'b1;
            end else if (err_clr) begin
                r_ov <= 1'b0;
            end
        end
    end

    // ---------------- receive FIFO ----------------
    uart_fifo_sa #(
        .W  (8),
        .AW (FIFO_AW)
    ) u_fifo (
        .i_clk   (m_clock),
        .i_rst_n (p_reset_n),
        .i_push  (w_push),
        .i_din   (r_sr),
        .o_full  (w_full),
        .i_pop   (read),
        .o_dout  (dout),
        .o_empty (w_empty)
    );

    assign valid       = ~w_empty;
    assign framing_err = r_fe;
    assign overrun     = r_ov;
    assign busy        = r_busy;
    assign dbg_state   = r_state;

endmodule
